// File: rtl/mac8_accumulator.sv
// Saturating frame accumulator behind the 8x8 multiplier: sums FRAME_LEN unsigned
// products and posts each frame total, with its sticky saturation flag, through a one-deep output register.
module mac8_accumulator #(
  parameter int unsigned ACC_W     = 24,
  parameter int unsigned FRAME_LEN = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      prod,
  input  logic             prod_valid,
  output logic             prod_ready,
  input  logic             clear,
  output logic [7:0]       count,
  output logic [ACC_W-1:0] res,
  output logic             res_sat,
  output logic             res_valid,
  input  logic             res_ready
);

  localparam logic [7:0]       LAST_CNT = 8'(FRAME_LEN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};
  localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

  // Returns {overflow, clamped sum}; a carry out of ACC_W bits pins the sum to all ones.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a, input logic [15:0] p);
    logic [ACC_W:0] full;
    full = {1'b0, a} + {{(ACC_W - 15){1'b0}}, p};
    if (full[ACC_W]) begin
      sat_add = {1'b1, ACC_MAX};
    end else begin
      sat_add = full;
    end
  endfunction

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       count_q, count_d;
  logic             sat_acc_q, sat_acc_d;
  logic [ACC_W-1:0] res_q, res_d;
  logic             res_sat_q, res_sat_d;
  logic             res_valid_q, res_valid_d;

  logic             last_s;
  logic             prod_ready_s;
  logic             accept_s;
  logic [ACC_W:0]   add_s;
  logic             ovf_s;
  logic [ACC_W-1:0] sat_sum_s;

  // Handshake qualification; prod_ready never looks at res_ready.
  always_comb begin
    last_s       = (count_q == LAST_CNT);
    prod_ready_s = !rst && !clear && !(last_s && res_valid_q);
    accept_s     = prod_valid && prod_ready_s;
    add_s        = sat_add(acc_q, prod);
    ovf_s        = add_s[ACC_W];
    sat_sum_s    = add_s[ACC_W-1:0];
  end

  // Running-frame state: clear aborts the frame, a last accept closes it.
  always_comb begin
    acc_d     = acc_q;
    count_d   = count_q;
    sat_acc_d = sat_acc_q;
    if (clear) begin
      acc_d     = ACC_ZERO;
      count_d   = 8'd0;
      sat_acc_d = 1'b0;
    end else if (accept_s) begin
      if (last_s) begin
        acc_d     = ACC_ZERO;
        count_d   = 8'd0;
        sat_acc_d = 1'b0;
      end else begin
        acc_d     = sat_sum_s;
        count_d   = count_q + 8'd1;
        sat_acc_d = sat_acc_q | ovf_s;
      end
    end else begin
      acc_d     = acc_q;
      count_d   = count_q;
      sat_acc_d = sat_acc_q;
    end
  end

  // Output register: a new frame result takes priority over the consumer handshake.
  always_comb begin
    res_d       = res_q;
    res_sat_d   = res_sat_q;
    res_valid_d = res_valid_q;
    if (accept_s && last_s) begin
      res_d       = sat_sum_s;
      res_sat_d   = sat_acc_q | ovf_s;
      res_valid_d = 1'b1;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end else begin
      res_valid_d = res_valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= ACC_ZERO;
      count_q     <= 8'd0;
      sat_acc_q   <= 1'b0;
      res_q       <= ACC_ZERO;
      res_sat_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      count_q     <= count_d;
      sat_acc_q   <= sat_acc_d;
      res_q       <= res_d;
      res_sat_q   <= res_sat_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign prod_ready = prod_ready_s;
  assign count      = count_q;
  assign res        = res_q;
  assign res_sat    = res_sat_q;
  assign res_valid  = res_valid_q;

endmodule
